// File: rtl/cpu_synth_ctrl.sv
// CPU-domain staging/hold register bank for the synth configuration, with a
// four-phase req/ack handshake that launches a frozen snapshot across the CDC.
//
//   state  | meaning
//   -------+--------------------------------------------------
//   S_IDLE | no transfer in flight, req low
//   S_REQ  | hold registers launched, req high, waiting ack=1
//   S_REL  | req dropped, waiting for ack=0 before next launch
module cpu_synth_ctrl #(
    parameter int N_VOICES = 1
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [7:0]            rd_addr,
    output logic [31:0]           rd_data,
    output logic [24*N_VOICES-1:0] cpu_carrier_fcws,
    output logic [23:0]           cpu_mod_fcw,
    output logic [4:0]            cpu_mod_shift,
    output logic [N_VOICES-1:0]   cpu_note_en,
    output logic [4:0]            cpu_synth_shift,
    output logic                  cpu_req,
    input  logic                  cpu_ack
);

    localparam int FW = 24 * N_VOICES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  pending_q;
    logic                  req_q;

    logic [FW-1:0]         stg_fcws_q;
    logic [23:0]           stg_mod_fcw_q;
    logic [4:0]            stg_mod_shift_q;
    logic [N_VOICES-1:0]   stg_note_en_q;
    logic [4:0]            stg_synth_shift_q;

    logic [FW-1:0]         hold_fcws_q;
    logic [23:0]           hold_mod_fcw_q;
    logic [4:0]            hold_mod_shift_q;
    logic [N_VOICES-1:0]   hold_note_en_q;
    logic [4:0]            hold_synth_shift_q;

    logic [5:0] wr_word;
    logic [5:0] rd_word;
    logic       commit_wr;
    logic       unused_bits;

    assign wr_word     = wr_addr[7:2];
    assign rd_word     = rd_addr[7:2];
    assign commit_wr   = wr_en && (wr_word == 6'h14);
    assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data[31:24]};

    // Staging registers: writable at any time, never touch the hold set.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            stg_fcws_q        <= '0;
            stg_mod_fcw_q     <= '0;
            stg_mod_shift_q   <= '0;
            stg_note_en_q     <= '0;
            stg_synth_shift_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (wr_word == 6'(i)) begin
                    stg_fcws_q[24*i +: 24] <= wr_data[23:0];
                end
            end
            case (wr_word)
                6'h10:   stg_mod_fcw_q     <= wr_data[23:0];
                6'h11:   stg_mod_shift_q   <= wr_data[4:0];
                6'h12:   stg_note_en_q     <= wr_data[N_VOICES-1:0];
                6'h13:   stg_synth_shift_q <= wr_data[4:0];
                default: ;
            endcase
        end
    end

    // Launch samples the staging _q values, so a same-cycle staging write is excluded.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q            <= S_IDLE;
            pending_q          <= 1'b0;
            req_q              <= 1'b0;
            hold_fcws_q        <= '0;
            hold_mod_fcw_q     <= '0;
            hold_mod_shift_q   <= '0;
            hold_note_en_q     <= '0;
            hold_synth_shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (commit_wr || pending_q) begin
                        state_q            <= S_REQ;
                        req_q              <= 1'b1;
                        pending_q          <= 1'b0;
                        hold_fcws_q        <= stg_fcws_q;
                        hold_mod_fcw_q     <= stg_mod_fcw_q;
                        hold_mod_shift_q   <= stg_mod_shift_q;
                        hold_note_en_q     <= stg_note_en_q;
                        hold_synth_shift_q <= stg_synth_shift_q;
                    end
                end
                S_REQ: begin
                    if (commit_wr) pending_q <= 1'b1;
                    if (cpu_ack) begin
                        state_q <= S_REL;
                        req_q   <= 1'b0;
                    end
                end
                S_REL: begin
                    if (commit_wr) pending_q <= 1'b1;
                    if (!cpu_ack) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (rd_word == 6'(i)) rd_data = {8'h00, stg_fcws_q[24*i +: 24]};
        end
        case (rd_word)
            6'h10:   rd_data = {8'h00, stg_mod_fcw_q};
            6'h11:   rd_data = 32'(stg_mod_shift_q);
            6'h12:   rd_data = 32'(stg_note_en_q);
            6'h13:   rd_data = 32'(stg_synth_shift_q);
            6'h15:   rd_data = {30'd0, pending_q, state_q != S_IDLE};
            default: ;
        endcase
    end

    assign cpu_carrier_fcws = hold_fcws_q;
    assign cpu_mod_fcw      = hold_mod_fcw_q;
    assign cpu_mod_shift    = hold_mod_shift_q;
    assign cpu_note_en      = hold_note_en_q;
    assign cpu_synth_shift  = hold_synth_shift_q;
    assign cpu_req          = req_q;

endmodule

// File: tb/tb_cpu_synth_ctrl.sv
// Bench for cpu_synth_ctrl (N_VOICES=2): register table plus handshake sequences,
// with launched snapshots tracked in a queue and checked against the hold outputs.
module tb_cpu_synth_ctrl;

    localparam int NV = 2;

    logic            cpu_clk;
    logic            cpu_rst_n;
    logic            wr_en;
    logic [7:0]      wr_addr;
    logic [31:0]     wr_data;
    logic [7:0]      rd_addr;
    logic [31:0]     rd_data;
    logic [24*NV-1:0] cpu_carrier_fcws;
    logic [23:0]     cpu_mod_fcw;
    logic [4:0]      cpu_mod_shift;
    logic [NV-1:0]   cpu_note_en;
    logic [4:0]      cpu_synth_shift;
    logic            cpu_req;
    logic            cpu_ack;

    cpu_synth_ctrl #(.N_VOICES(NV)) dut (
        .cpu_clk          (cpu_clk),
        .cpu_rst_n        (cpu_rst_n),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .cpu_carrier_fcws (cpu_carrier_fcws),
        .cpu_mod_fcw      (cpu_mod_fcw),
        .cpu_mod_shift    (cpu_mod_shift),
        .cpu_note_en      (cpu_note_en),
        .cpu_synth_shift  (cpu_synth_shift),
        .cpu_req          (cpu_req),
        .cpu_ack          (cpu_ack)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [47:0] fcws;
        logic [23:0] mod_fcw;
        logic [4:0]  mod_shift;
        logic [1:0]  note;
        logic [4:0]  synth;
    } snap_t;

    typedef struct {
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int rise_cnt = 0;
    logic req_prev = 1'b0;

    snap_t launch_q[$];
    snap_t exp_hold = '{default: '0};
    logic [31:0] rd_q[$];

    logic [47:0] m_fcws;
    logic [23:0] m_mod_fcw;
    logic [4:0]  m_mod_shift;
    logic [1:0]  m_note;
    logic [4:0]  m_synth;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_fcws = '0; m_mod_fcw = '0; m_mod_shift = '0; m_note = '0; m_synth = '0;
    endfunction

    function automatic void push_snap();
        snap_t s;
        s.fcws = m_fcws; s.mod_fcw = m_mod_fcw; s.mod_shift = m_mod_shift;
        s.note = m_note; s.synth = m_synth;
        launch_q.push_back(s);
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        case (a[7:2])
            6'h00:   return {8'h00, m_fcws[23:0]};
            6'h01:   return {8'h00, m_fcws[47:24]};
            6'h10:   return {8'h00, m_mod_fcw};
            6'h11:   return {27'd0, m_mod_shift};
            6'h12:   return {30'd0, m_note};
            6'h13:   return {27'd0, m_synth};
            default: return 32'd0;
        endcase
    endfunction

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge cpu_clk);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        case (a[7:2])
            6'h00: m_fcws[23:0]  = d[23:0];
            6'h01: m_fcws[47:24] = d[23:0];
            6'h10: m_mod_fcw     = d[23:0];
            6'h11: m_mod_shift   = d[4:0];
            6'h12: m_note        = d[1:0];
            6'h13: m_synth       = d[4:0];
            default: ;
        endcase
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic cyc_busy(input int n);
        logic [31:0] v;
        repeat (n) begin
            @(negedge cpu_clk);
            rd(8'h54, v);
            check("status_busy", {63'd0, v[0]}, 64'd1);
        end
    endtask

    task automatic wait_req(input logic lvl, input string nm);
        int n = 0;
        while (cpu_req !== lvl && n < 40) begin
            @(negedge cpu_clk);
            n++;
        end
        check(nm, {63'd0, cpu_req}, {63'd0, lvl});
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] v;
        int n = 0;
        rd(8'h54, v);
        while (v[0] !== 1'b0 && n < 40) begin
            @(negedge cpu_clk);
            rd(8'h54, v);
            n++;
        end
        check(nm, {63'd0, v[0]}, 64'd0);
    endtask

    task automatic readback_all(input string nm);
        logic [31:0] v;
        logic [7:0] addrs [6] = '{8'h00, 8'h04, 8'h40, 8'h44, 8'h48, 8'h4C};
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], v);
            check(nm, {32'd0, v}, {32'd0, exp_read(addrs[i])});
        end
    endtask

    // Hold outputs must equal the most recently launched snapshot at every cycle.
    always @(negedge cpu_clk) begin
        if (!cpu_rst_n) begin
            exp_hold = '{default: '0};
            req_prev = 1'b0;
        end else begin
            if (cpu_req && !req_prev) begin
                rise_cnt++;
                check("launch_q_depth", 64'(launch_q.size() > 0), 64'd1);
                if (launch_q.size() > 0) exp_hold = launch_q.pop_front();
            end
            req_prev = cpu_req;
        end
        check("hold_fcws",      {16'd0, cpu_carrier_fcws}, {16'd0, exp_hold.fcws});
        check("hold_mod_fcw",   {40'd0, cpu_mod_fcw},      {40'd0, exp_hold.mod_fcw});
        check("hold_mod_shift", {59'd0, cpu_mod_shift},    {59'd0, exp_hold.mod_shift});
        check("hold_note_en",   {62'd0, cpu_note_en},      {62'd0, exp_hold.note});
        check("hold_synth",     {59'd0, cpu_synth_shift},  {59'd0, exp_hold.synth});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        logic [31:0] v;
        int r0;

        tbl[0] = '{8'h00, 32'h0012_3456, 8'h00, 32'h0012_3456};
        tbl[1] = '{8'h07, 32'hFFAB_CDEF, 8'h04, 32'h00AB_CDEF};
        tbl[2] = '{8'h40, 32'h1200_0ABC, 8'h40, 32'h0000_0ABC};
        tbl[3] = '{8'h44, 32'hFFFF_FFE7, 8'h44, 32'h0000_0007};
        tbl[4] = '{8'h48, 32'hFFFF_FFFD, 8'h48, 32'h0000_0001};
        tbl[5] = '{8'h4C, 32'h0000_0023, 8'h4E, 32'h0000_0003};
        tbl[6] = '{8'h08, 32'hDEAD_BEEF, 8'h08, 32'h0000_0000};
        tbl[7] = '{8'h58, 32'hDEAD_BEEF, 8'h58, 32'h0000_0000};
        tbl[8] = '{8'h54, 32'hFFFF_FFFF, 8'h54, 32'h0000_0000};
        tbl[9] = '{8'h5C, 32'h0000_0001, 8'h50, 32'h0000_0000};

        cpu_rst_n = 1'b1; cpu_ack = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_clear();
        #3 cpu_rst_n = 1'b0;
        repeat (2) @(negedge cpu_clk);
        check("rst_req", {63'd0, cpu_req}, 64'd0);
        check("rst_fcws", {16'd0, cpu_carrier_fcws}, 64'd0);
        rd(8'h54, v);
        check("rst_status", {32'd0, v}, 64'd0);
        rd(8'h00, v);
        check("rst_rd00", {32'd0, v}, 64'd0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);

        // Register map table: write, then read back through the scoreboard queue.
        for (int i = 0; i < 10; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd_q.push_back(tbl[i].exp);
            rd(tbl[i].raddr, v);
            check("tbl_rd", {32'd0, v}, {32'd0, rd_q.pop_front()});
        end
        readback_all("tbl_readback");
        check("tbl_no_launch", 64'(rise_cnt), 64'd0);

        // Basic transfer plus hold stability under a staging write during REQ.
        wr(8'h00, 32'h0012_3456); wr(8'h40, 32'h0000_0ABC); wr(8'h44, 32'd7);
        wr(8'h48, 32'd1); wr(8'h4C, 32'd3);
        push_snap();
        r0 = rise_cnt;
        wr(8'h50, 32'hFFFF_FFFF);
        check("basic_req_up", {63'd0, cpu_req}, 64'd1);
        check("basic_v0", {40'd0, cpu_carrier_fcws[23:0]}, 64'h12_3456);
        check("basic_mod_fcw", {40'd0, cpu_mod_fcw}, 64'h000ABC);
        check("basic_mod_shift", {59'd0, cpu_mod_shift}, 64'd7);
        check("basic_note", {62'd0, cpu_note_en}, 64'd1);
        check("basic_synth", {59'd0, cpu_synth_shift}, 64'd3);
        wr(8'h00, 32'h00FF_FFFF);
        rd(8'h00, v);
        check("stable_rd00", {32'd0, v}, 64'hFF_FFFF);
        check("stable_hold_v0", {40'd0, cpu_carrier_fcws[23:0]}, 64'h12_3456);
        cyc_busy(2);
        cpu_ack = 1'b1;
        wait_req(1'b0, "basic_req_down");
        cyc_busy(3);
        cpu_ack = 1'b0;
        wait_idle("basic_idle");
        repeat (2) @(negedge cpu_clk);
        check("basic_one_rise", 64'(rise_cnt - r0), 64'd1);

        // Pending: three commits during REL collapse into one launch at B+1.
        push_snap();
        r0 = rise_cnt;
        wr(8'h50, 32'd0);
        cyc_busy(2);
        cpu_ack = 1'b1;
        wait_req(1'b0, "pend_req_down");
        wr(8'h04, 32'h000B_EEF0);
        wr(8'h44, 32'h0000_001F);
        wr(8'h50, 32'd0); wr(8'h50, 32'd0); wr(8'h50, 32'd0);
        rd(8'h54, v);
        check("pend_status_rel", {32'd0, v}, 64'd3);
        push_snap();
        cpu_ack = 1'b0;
        @(negedge cpu_clk);
        check("pend_gap_req", {63'd0, cpu_req}, 64'd0);
        rd(8'h54, v);
        check("pend_status_idle", {32'd0, v}, 64'd2);
        @(negedge cpu_clk);
        check("pend_launch_req", {63'd0, cpu_req}, 64'd1);
        rd(8'h54, v);
        check("pend_cleared", {32'd0, v}, 64'd1);
        cyc_busy(3);
        cpu_ack = 1'b1;
        wait_req(1'b0, "pend2_req_down");
        cyc_busy(2);
        cpu_ack = 1'b0;
        wait_idle("pend_idle");
        repeat (3) @(negedge cpu_clk);
        check("pend_rises", 64'(rise_cnt - r0), 64'd2);
        check("pend_q_empty", 64'(launch_q.size()), 64'd0);

        // Stuck ack: REL persists, a commit only sets pending until ack drops.
        wr(8'h00, 32'h0000_0042);
        push_snap();
        r0 = rise_cnt;
        wr(8'h50, 32'd0);
        cyc_busy(1);
        cpu_ack = 1'b1;
        wait_req(1'b0, "stuck_req_down");
        cyc_busy(8);
        wr(8'h48, 32'd2);
        wr(8'h50, 32'd0);
        push_snap();
        cyc_busy(6);
        rd(8'h54, v);
        check("stuck_pending", {32'd0, v}, 64'd3);
        check("stuck_req_low", {63'd0, cpu_req}, 64'd0);
        check("stuck_one_rise", 64'(rise_cnt - r0), 64'd1);
        cpu_ack = 1'b0;
        wait_req(1'b1, "stuck_relaunch");
        rd(8'h54, v);
        check("stuck_pend_clr", {32'd0, v}, 64'd1);
        cyc_busy(2);
        cpu_ack = 1'b1;
        wait_req(1'b0, "stuck2_req_down");
        cpu_ack = 1'b0;
        wait_idle("stuck_idle");
        @(negedge cpu_clk);

        // Reset in the middle of a handshake.
        wr(8'h4C, 32'd9);
        push_snap();
        wr(8'h50, 32'd0);
        wait_req(1'b1, "mrst_req_up");
        #2 cpu_rst_n = 1'b0;
        #1;
        check("mrst_req", {63'd0, cpu_req}, 64'd0);
        check("mrst_fcws", {16'd0, cpu_carrier_fcws}, 64'd0);
        check("mrst_synth", {59'd0, cpu_synth_shift}, 64'd0);
        rd(8'h54, v);
        check("mrst_status", {32'd0, v}, 64'd0);
        model_clear();
        readback_all("mrst_readback");
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        repeat (3) @(negedge cpu_clk);
        check("final_q_empty", 64'(launch_q.size()), 64'd0);
        check("final_req", {63'd0, cpu_req}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_synth_ctrl.md
# cpu_synth_ctrl

CPU-clock-domain control bank that sits directly upstream of the CPU-to-synth clock-domain crossing. The CPU writes the next synthesizer configuration into staging registers over MMIO: per-voice carrier FCWs, modulator FCW and shift, note enables, and output shift. A commit write snapshots the staged values into hold registers, and a four-phase req/ack handshake then transfers them to the synth domain. The hold registers stay frozen for the whole handshake, so the crossing always samples a coherent set.

## Interface
- `N_VOICES`, default 1: number of carrier voices, legal range 1..16.
- `cpu_clk` input, 1 bit: CPU clock. Single clock for the block.
- `cpu_rst_n` input, 1 bit: asynchronous, active-low reset.
- `wr_en` input, 1 bit: MMIO write strobe, one cycle per write.
- `wr_addr` input, 8 bits: byte address of the write. Bits [1:0] are ignored.
- `wr_data` input, 32 bits: write data.
- `rd_addr` input, 8 bits: read address.
- `rd_data` output, 32 bits: combinational read data.
- `cpu_carrier_fcws` output, 24*N_VOICES bits: held carrier FCWs. Voice i occupies [24i+23:24i].
- `cpu_mod_fcw` output, 24 bits: held modulator FCW.
- `cpu_mod_shift` output, 5 bits: held modulator shift.
- `cpu_note_en` output, N_VOICES bits: held note enables.
- `cpu_synth_shift` output, 5 bits: held synth output shift.
- `cpu_req` output, 1 bit: handshake request to the CDC.
- `cpu_ack` input, 1 bit: handshake acknowledge from the CDC, already synchronized into `cpu_clk`.

## Operation
- Register map. Reads return zero-extended values.
  - 0x00+4i: staged carrier FCW for voice i, bits [23:0].
  - 0x40: mod FCW, bits [23:0].
  - 0x44: mod shift, bits [4:0].
  - 0x48: note enables, bits [N_VOICES-1:0].
  - 0x4C: synth shift, bits [4:0].
  - 0x50: COMMIT, write-only. The written data is ignored and reads return 0.
  - 0x54: STATUS, read-only. Bit0 is busy (FSM not IDLE). Bit1 is pending.
- Writes to unmapped addresses, voice indices ≥ N_VOICES, or STATUS are dropped. Writes to staging registers are legal at any time and never disturb the hold registers.
- FSM states:
  - IDLE: req=0.
  - REQ: req=1; waiting for ack=1.
  - REL: req=0; waiting for ack=0.
- FSM transitions:
  - IDLE → REQ when a commit is seen (COMMIT write, or `pending` set). Same edge: hold ← staging and `pending` ← 0.
  - REQ → REL on the first edge that samples ack=1.
  - REL → IDLE on the first edge that samples ack=0.
- A COMMIT write in REQ or REL sets `pending`. Repeated commits collapse into a single pending flag. The hold registers are not touched.
- The launch snapshot captures staging as of that edge. A staging write in the same cycle as the COMMIT write is not included; the value before the write is snapshotted.
- ack=1 observed in IDLE is ignored. ack staying 1 keeps the FSM in REL indefinitely; there is no timeout.

## Timing
- Reset (asynchronous assert, synchronous-release by the system):
  - All staging and hold registers are 0.
  - `cpu_req`=0, FSM=IDLE, `pending`=0, `rd_data` reflects zeros.
- `rd_data` is combinational from `rd_addr` and the current register state. A write is visible on reads in the cycle after `wr_en`.
- COMMIT at edge T (FSM IDLE): the hold outputs update and `cpu_req`=1 after edge T.
- ack seen high at edge A: `cpu_req`=0 after A.
- ack seen low at edge B: FSM is IDLE after B.
- If `pending` is set, REQ is entered at edge B+1, so `cpu_req` is low for at least one cycle between transfers.
- The hold outputs are constant from the launch edge until the block re-enters IDLE. Minimum transfer is 3 cycles of `cpu_req` high/low plus the round-trip CDC latency.
- Reset mid-handshake immediately drops `cpu_req` and clears the FSM and all registers. The downstream CDC tolerates an abandoned request.

## Test plan
- **Reset:** assert `cpu_rst_n`=0 mid-cycle. Required: all outputs 0 immediately; STATUS reads 0.
- **Basic transfer:** write voice 0 FCW = 0x123456, mod FCW = 0x000ABC, mod shift = 7, note_en = 1, synth shift = 3, then COMMIT. Ack model: ack=1 4 cycles after req rises, ack=0 4 cycles after req falls. Required:
  - The hold outputs show exactly these values one cycle after COMMIT.
  - req rises and falls once.
  - STATUS busy is 1 throughout and returns to 0.
- **Hold stability:** during REQ, write voice 0 FCW = 0xFFFFFF. Required: `cpu_carrier_fcws` stays 0x123456 until the next launch; readback of 0x00 returns 0xFFFFFF.
- **Pending:** issue 3 COMMITs during REL. Required:
  - Exactly one further transfer starts at B+1 and carries the latest staging values.
  - `pending` clears on that launch.
  - req is low for at least 1 cycle between transfers.
- **Illegal writes:** with N_VOICES=2, write addresses 0x08 and 0x58 with data 0xDEADBEEF. Required: no register changes; reads of 0x08 and 0x58 return 0.
- **Stuck ack:** hold ack=1 after req falls. Required: FSM stays in REL and busy stays 1; a COMMIT sets `pending` only. Releasing ack launches the pending transfer.
